// File: rtl/reg_bus_master_if.sv
// Command/response channels plus target-side bus for reg_bus_master.
// The master modport is the initiator's view; slave is the sequencer/target side.
interface reg_bus_master_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 16
);
  logic              cmdValid;
  logic              cmdReady;
  logic              cmdWrite;
  logic [ADDR_W-1:0] cmdAddr;
  logic [DATA_W-1:0] cmdData;

  logic              rspValid;
  logic              rspReady;
  logic              rspWrite;
  logic [DATA_W-1:0] rspData;

  logic [ADDR_W-1:0] addressBus;
  logic [DATA_W-1:0] writeDataBus;
  logic [DATA_W-1:0] readDataBus;
  logic              writeToReg;
  logic              readFromReg;
  logic              busy;

  modport master (
    input  cmdValid, cmdWrite, cmdAddr, cmdData, rspReady, readDataBus,
    output cmdReady, rspValid, rspWrite, rspData, addressBus, writeDataBus,
    output writeToReg, readFromReg, busy
  );

  modport slave (
    output cmdValid, cmdWrite, cmdAddr, cmdData, rspReady, readDataBus,
    input  cmdReady, rspValid, rspWrite, rspData, addressBus, writeDataBus,
    input  writeToReg, readFromReg, busy
  );
endinterface

// File: rtl/reg_bus_master.sv
// Single-command initiator for the register/memory bus: address setup, one-cycle strobe,
// fixed-latency read capture, and a held response until the consumer takes it.
module reg_bus_master #(
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  reg_bus_master_if.master bus
);

  localparam logic [3:0] LatLoad = 4'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmdValid) begin
          state_d = StSetup;
          write_d = bus.cmdWrite;
          addr_d  = bus.cmdAddr;
          wdata_d = bus.cmdWrite ? bus.cmdData : '0;
          // Write responses report zero data, so drop any previous read capture.
          rdata_d = '0;
        end
      end
      StSetup: begin
        state_d = StStrobe;
      end
      StStrobe: begin
        if (write_q) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = LatLoad;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          rdata_d = bus.readDataBus;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rspReady) begin
          state_d = StIdle;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // cmdReady is gated by reset so it reads 0 while reset is held, not just after.
  assign bus.cmdReady     = (state_q == StIdle) && reset;
  assign bus.busy         = (state_q != StIdle);
  assign bus.rspValid     = (state_q == StResp);
  assign bus.rspWrite     = write_q;
  assign bus.rspData      = rdata_q;
  assign bus.addressBus   = addr_q;
  assign bus.writeDataBus = wdata_q;
  assign bus.writeToReg   = (state_q == StStrobe) &&  write_q;
  assign bus.readFromReg  = (state_q == StStrobe) && !write_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: a vector table of write/read transactions against a
// small target memory, plus hand-written latency, backpressure, abort and streaming cases.
module tb_reg_bus_master;
  localparam int unsigned DW = 256;
  localparam int unsigned AW = 16;

  localparam logic [DW-1:0] P1 =
    256'h0017_002d_0043_0016_0007_0006_0004_0001_0012_0038_000d_000c_0003_0005_0007_0009;
  localparam logic [DW-1:0] P2 =
    256'h0004_000c_0004_0022_0007_0006_000b_0009_0009_0002_0008_000d_0002_000f_0010_0003;
  localparam logic [DW-1:0] P3 =
    256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
  localparam logic [DW-1:0] EARLY =
    256'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
  localparam logic [DW-1:0] GOOD =
    256'h600d_0001_600d_0002_600d_0003_600d_0004_600d_0005_600d_0006_600d_0007_600d_0008;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  reg_bus_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  reg_bus_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

  reg_bus_master #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1)) dut1 (
    .clk  (clk),
    .reset(rst1),
    .bus  (bus1)
  );

  reg_bus_master #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(3)) dut3 (
    .clk  (clk),
    .reset(rst3),
    .bus  (bus3)
  );

  // Target for dut1: registered read data, valid one cycle after the strobe edge.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (bus1.writeToReg)  mem[bus1.addressBus[7:4]] <= bus1.writeDataBus;
    if (bus1.readFromReg) bus1.readDataBus <= mem[bus1.addressBus[7:4]];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  // One full transaction on dut1, starting and ending at a negedge in IDLE with rspReady=1.
  task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] exp);
    int  k;
    logic got;
    check("cmd_ready_idle", bus1.cmdReady, 1);
    bus1.cmdValid = 1'b1;
    bus1.cmdWrite = wr;
    bus1.cmdAddr  = a;
    bus1.cmdData  = d;
    @(negedge clk);
    bus1.cmdValid = 1'b0;
    check("setup_addr", bus1.addressBus, a);
    check("setup_wdata", bus1.writeDataBus, wr ? d : '0);
    check("setup_strobes", {bus1.writeToReg, bus1.readFromReg}, 0);
    check("setup_busy", bus1.busy, 1);
    @(negedge clk);
    check("strobe", {bus1.writeToReg, bus1.readFromReg}, wr ? 2'b10 : 2'b01);
    check("strobe_addr", bus1.addressBus, a);
    k   = 1;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (bus1.rspValid) got = 1'b1;
      else check("wait_strobes", {bus1.writeToReg, bus1.readFromReg}, 0);
    end
    check("rsp_latency", k, wr ? 2 : 3);
    check("rsp_data", bus1.rspData, exp);
    check("rsp_write", bus1.rspWrite, wr);
    check("rsp_strobes", {bus1.writeToReg, bus1.readFromReg}, 0);
    @(negedge clk);
    check("post_busy", bus1.busy, 0);
    check("post_cmd_ready", bus1.cmdReady, 1);
    check("post_addr_zero", bus1.addressBus, 0);
    check("post_wdata_zero", bus1.writeDataBus, 0);
  endtask

  initial begin
    int k;
    int st[$];

    vecs[0] = '{wr: 1'b1, addr: 16'h4000, data: P1, exp: '0};
    vecs[1] = '{wr: 1'b0, addr: 16'h4000, data: P3, exp: P1};
    vecs[2] = '{wr: 1'b1, addr: 16'h4000, data: P2, exp: '0};
    vecs[3] = '{wr: 1'b0, addr: 16'h4000, data: '0, exp: P2};
    vecs[4] = '{wr: 1'b1, addr: 16'h4010, data: P3, exp: '0};
    vecs[5] = '{wr: 1'b0, addr: 16'h4000, data: '0, exp: P2};
    vecs[6] = '{wr: 1'b0, addr: 16'h4010, data: '0, exp: P3};

    rst1 = 1'b0;
    rst3 = 1'b0;
    bus1.cmdValid = 1'b0; bus1.cmdWrite = 1'b0; bus1.cmdAddr = '0; bus1.cmdData = '0;
    bus1.rspReady = 1'b1;
    bus3.cmdValid = 1'b0; bus3.cmdWrite = 1'b0; bus3.cmdAddr = '0; bus3.cmdData = '0;
    bus3.rspReady = 1'b1; bus3.readDataBus = '0;

    // Reset state
    #1;
    check("rst_cmd_ready", bus1.cmdReady, 0);
    check("rst_rsp", {bus1.rspValid, bus1.rspWrite}, 0);
    check("rst_rsp_data", bus1.rspData, 0);
    check("rst_addr", bus1.addressBus, 0);
    check("rst_wdata", bus1.writeDataBus, 0);
    check("rst_strobes_busy", {bus1.writeToReg, bus1.readFromReg, bus1.busy}, 0);
    check("rst3_cmd_ready", bus3.cmdReady, 0);
    repeat (2) @(negedge clk);
    rst1 = 1'b1;
    rst3 = 1'b1;
    #1;
    check("rel_cmd_ready", bus1.cmdReady, 1);
    check("rel3_cmd_ready", bus3.cmdReady, 1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
    end

    // READ_LATENCY=3: a stale value one cycle early must not be captured
    bus3.cmdValid = 1'b1;
    bus3.cmdWrite = 1'b0;
    bus3.cmdAddr  = 16'h4020;
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      if (e == 0) bus3.cmdValid = 1'b0;
      if (e == 1) check("rl3_strobe", bus3.readFromReg, 1);
      check("rl3_rsp_valid", bus3.rspValid, (e == 5) ? 1 : 0);
      if (e == 3) bus3.readDataBus = EARLY;
      if (e == 4) bus3.readDataBus = GOOD;
    end
    check("rl3_rsp_data", bus3.rspData, GOOD);
    check("rl3_rsp_write", bus3.rspWrite, 0);
    check("rl3_addr", bus3.addressBus, 16'h4020);
    @(negedge clk);
    check("rl3_idle", bus3.busy, 0);

    // Response backpressure with a pending command
    bus1.rspReady = 1'b0;
    bus1.cmdValid = 1'b1;
    bus1.cmdWrite = 1'b0;
    bus1.cmdAddr  = 16'h4000;
    @(negedge clk);
    bus1.cmdValid = 1'b0;
    k = 0;
    while (!bus1.rspValid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_rsp_seen", bus1.rspValid, 1);
    bus1.cmdValid = 1'b1;
    bus1.cmdWrite = 1'b1;
    bus1.cmdAddr  = 16'h4040;
    bus1.cmdData  = P1;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", bus1.rspValid, 1);
      check("bp_rsp_data", bus1.rspData, P2);
      check("bp_addr", bus1.addressBus, 16'h4000);
      check("bp_cmd_ready", bus1.cmdReady, 0);
      check("bp_strobes", {bus1.writeToReg, bus1.readFromReg}, 0);
      @(negedge clk);
    end
    bus1.rspReady = 1'b1;
    @(negedge clk);
    check("bp_release_busy", bus1.busy, 0);
    check("bp_release_ready", bus1.cmdReady, 1);
    check("bp_release_addr", bus1.addressBus, 0);
    @(negedge clk);
    bus1.cmdValid = 1'b0;
    check("bp_accept_busy", bus1.busy, 1);
    check("bp_accept_addr", bus1.addressBus, 16'h4040);
    k = 0;
    while (!bus1.rspValid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_wr_rsp", {bus1.rspValid, bus1.rspWrite}, 2'b11);
    check("bp_wr_rsp_data", bus1.rspData, 0);
    @(negedge clk);

    // Asynchronous reset during the write strobe
    bus1.cmdValid = 1'b1;
    bus1.cmdWrite = 1'b1;
    bus1.cmdAddr  = 16'h4050;
    bus1.cmdData  = P3;
    @(negedge clk);
    bus1.cmdValid = 1'b0;
    @(negedge clk);
    check("abort_strobe_on", bus1.writeToReg, 1);
    #2 rst1 = 1'b0;
    #1;
    check("abort_strobe_off", {bus1.writeToReg, bus1.readFromReg}, 0);
    check("abort_addr", bus1.addressBus, 0);
    check("abort_wdata", bus1.writeDataBus, 0);
    check("abort_busy_ready", {bus1.busy, bus1.cmdReady, bus1.rspValid}, 0);
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    check("abort_rel_ready", bus1.cmdReady, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", {bus1.rspValid, bus1.writeToReg, bus1.busy}, 0);
    end

    // Back-to-back writes with cmdValid held
    bus1.cmdValid = 1'b1;
    bus1.cmdWrite = 1'b1;
    bus1.cmdAddr  = 16'h4060;
    bus1.cmdData  = P2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.writeToReg) st.push_back(i);
      check("b2b_no_read", bus1.readFromReg, 0);
      if (i == 19) bus1.cmdValid = 1'b0;
    end
    check("b2b_count", st.size(), 5);
    for (int i = 1; i < st.size(); i++) begin
      check("b2b_period", st[i] - st[i-1], 4);
    end
    @(negedge clk);
    check("b2b_idle", bus1.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
